// File: rtl/non_restoring_div_ctrl.sv
// Sequenced unsigned non-restoring divider: X / Y -> Q, R.
// Each ITER cycle shifts {A,Qr} left, then adds or subtracts the divisor.
// After the last step, one FIX cycle corrects a negative remainder.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             request, sampled only in IDLE together with X, Y
//   X, Y              dividend, divisor
//   busy              operation in progress (ITER, FIX)
//   done              one-cycle completion pulse
//   Q, R              quotient / remainder, held until the next completion
//   div_by_zero       set with done when Y was zero, held like Q/R
module non_restoring_div_ctrl #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             div_by_zero
);

   localparam int unsigned AW = WIDTH + 1;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ITER,
      S_FIX,
      S_DONE,
      S_ZERO
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [AW-1:0]    a;
   logic [AW-1:0]    m;
   logic [WIDTH-1:0] qr;
   logic [CW-1:0]    count;

   logic [AW-1:0]    a_sh;
   logic [AW-1:0]    a_step;
   logic [AW-1:0]    a_fix;
   logic [WIDTH-1:0] qr_step;
   logic             busy_nxt;
   logic             done_nxt;

   // One non-restoring step; the sign of A before the shift picks add vs subtract.
   always_comb begin
      a_sh    = {a[WIDTH-1:0], qr[WIDTH-1]};
      a_step  = a[WIDTH] ? (a_sh + m) : (a_sh - m);
      qr_step = {qr[WIDTH-2:0], ~a_step[WIDTH]};
      a_fix   = a[WIDTH] ? (a + m) : a;
   end

   // Next-state and registered-output decode.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = (Y == '0) ? S_ZERO : S_ITER;
         S_ITER: if (count == CW'(1)) state_nxt = S_FIX;
         S_FIX:  state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         S_ZERO: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      busy_nxt = (state_nxt == S_ITER) || (state_nxt == S_FIX);
      done_nxt = (state_nxt == S_DONE) || (state_nxt == S_ZERO);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a           <= '0;
         m           <= '0;
         qr          <= '0;
         count       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         Q           <= '0;
         R           <= '0;
         div_by_zero <= 1'b0;
      end else begin
         busy <= busy_nxt;
         done <= done_nxt;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (Y != '0) begin
                     a     <= '0;
                     qr    <= X;
                     m     <= {1'b0, Y};
                     count <= CW'(WIDTH);
                  end else begin
                     // Results for divide-by-zero are committed on the accepting edge.
                     Q           <= '1;
                     R           <= X;
                     div_by_zero <= 1'b1;
                  end
               end
            end
            S_ITER: begin
               a     <= a_step;
               qr    <= qr_step;
               count <= count - CW'(1);
            end
            S_FIX: begin
               a           <= a_fix;
               R           <= a_fix[WIDTH-1:0];
               Q           <= qr;
               div_by_zero <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_non_restoring_div_ctrl.sv
// Self-checking bench for non_restoring_div_ctrl (WIDTH=4): directed cases,
// mid-operation restart/reset, exhaustive sweep and random operations.
module tb_non_restoring_div_ctrl;

   localparam int unsigned WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] X;
   logic [WIDTH-1:0] Y;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] R;
   logic             div_by_zero;

   int n_checks;
   int n_fail;
   int prev_q;
   int prev_r;
   int prev_dz;

   non_restoring_div_ctrl #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .X           (X),
      .Y           (Y),
      .busy        (busy),
      .done        (done),
      .Q           (Q),
      .R           (R),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Runs one operation starting from an IDLE sample point (#1 after an edge),
   // checks cycle-by-cycle handshake and results, and ends in the IDLE cycle after done.
   task automatic run_op(input int x, input int y, input bit noise);
      int  exp_cyc;
      int  eq;
      int  er;
      int  edz;
      bit  seen;
      exp_cyc = (y == 0) ? 1 : int'(WIDTH) + 2;
      eq      = (y == 0) ? 15 : x / y;
      er      = (y == 0) ? x : x % y;
      edz     = (y == 0) ? 1 : 0;
      seen    = 1'b0;
      start = 1'b1;
      X     = WIDTH'(x);
      Y     = WIDTH'(y);
      @(posedge clk); #1;
      start = 1'b0;
      X     = WIDTH'($urandom_range(15));
      Y     = WIDTH'($urandom_range(15));
      for (int k = 1; k <= 12 && !seen; k++) begin
         if (k == exp_cyc) begin
            check("done_pulse", int'(done), 1);
            check("busy_at_done", int'(busy), 0);
            check("q", int'(Q), eq);
            check("r", int'(R), er);
            check("div_by_zero", int'(div_by_zero), edz);
            if (y != 0) begin
               check("invariant", int'(Q) * y + int'(R), x);
               check("r_lt_y", (int'(R) < y) ? 1 : 0, 1);
            end
            prev_q  = eq;
            prev_r  = er;
            prev_dz = edz;
            seen    = 1'b1;
         end else begin
            check("done_early", int'(done), 0);
            check("busy", int'(busy), (y != 0 && k <= int'(WIDTH) + 1) ? 1 : 0);
            check("q_hold", int'(Q), prev_q);
            check("r_hold", int'(R), prev_r);
            check("dz_hold", int'(div_by_zero), prev_dz);
            if (noise && k >= 2 && k <= 5) begin
               start = 1'b1;
               X     = WIDTH'(1);
               Y     = WIDTH'(1);
            end else begin
               start = 1'b0;
            end
            @(posedge clk); #1;
         end
      end
      if (!seen) check("done_timeout", 0, 1);
      start = 1'b0;
      @(posedge clk); #1;
      check("done_single", int'(done), 0);
      check("busy_idle", int'(busy), 0);
      check("q_after", int'(Q), prev_q);
      check("r_after", int'(R), prev_r);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      prev_q   = 0;
      prev_r   = 0;
      prev_dz  = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      X        = '0;
      Y        = '0;
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_q", int'(Q), 0);
      check("rst_r", int'(R), 0);
      check("rst_dz", int'(div_by_zero), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed cases
      run_op(13, 3, 1'b0);
      run_op(15, 1, 1'b0);
      run_op(3, 7, 1'b0);
      run_op(0, 5, 1'b0);
      run_op(9, 0, 1'b0);
      run_op(6, 2, 1'b0);
      // Restart attempts while busy are ignored
      run_op(13, 3, 1'b1);

      // Reset in cycle 3 of a 14/5 operation
      start = 1'b1;
      X     = WIDTH'(14);
      Y     = WIDTH'(5);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_q", int'(Q), 0);
      check("abort_r", int'(R), 0);
      check("abort_dz", int'(div_by_zero), 0);
      prev_q  = 0;
      prev_r  = 0;
      prev_dz = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("abort_no_done", int'(done), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(14, 5, 1'b0);

      // Exhaustive sweep, back-to-back
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            run_op(x, y, 1'b0);

      // Random operations with random restart noise
      for (int i = 0; i < 60; i++)
         run_op(int'($urandom_range(15)), int'($urandom_range(15)), 1'($urandom_range(1)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
